// File: rtl/axi_dma_w_arb_pkg.sv
// Shared types and constants for the burst-granular AXI write-DMA arbiter.
package axi_dma_w_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_e;

   localparam int unsigned BURST_LEN_DEF = 16;

   // Counter must hold 0..BURST_LEN-1 with one spare bit of headroom.
   function automatic int unsigned burst_cnt_w(input int unsigned burst_len);
      return $clog2(burst_len) + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_comb.sv
// Combinational requester select: round-robin from ptr, or fixed lowest-index
// priority when AXI_DMA_W_ARB_PRIO_EN is defined.
module rr_arbiter_comb
   import axi_dma_w_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned PTR_W = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] win_onehot_c,
   output logic [PTR_W-1:0] win_idx_c
);

`ifdef AXI_DMA_W_ARB_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr;
`endif

   // Scan in descending search order so the first candidate is written last.
   always_comb begin
      win_onehot_c = '0;
      win_idx_c    = '0;
`ifdef AXI_DMA_W_ARB_PRIO_EN
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (|(req & (N_REQ'(1) << i))) begin
            win_onehot_c = N_REQ'(1) << i;
            win_idx_c    = PTR_W'(i);
         end
      end
`else
      for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
         if (|(req & (N_REQ'(1) << ((int'(ptr) + k) % int'(N_REQ))))) begin
            win_onehot_c = N_REQ'(1) << ((int'(ptr) + k) % int'(N_REQ));
            win_idx_c    = PTR_W'((int'(ptr) + k) % int'(N_REQ));
         end
      end
`endif
   end

endmodule

// File: rtl/axi_dma_w_arb.sv
// Shares one AXI write-DMA databus among N_REQ requesters, one BURST_LEN burst
// per grant. Define AXI_DMA_W_ARB_PRIO_EN for fixed lowest-index priority.
module axi_dma_w_arb
   import axi_dma_w_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = 2,
   parameter int unsigned ADDR_W    = 30,
   parameter int unsigned DATA_W    = 256,
   parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*ADDR_W-1:0]     req_addr,
   input  logic [N_REQ*DATA_W-1:0]     req_wdata,
   input  logic [N_REQ*DATA_W/8-1:0]   req_wstrb,
   output logic [N_REQ-1:0]            req_ready,
   output logic                        dma_valid,
   output logic [ADDR_W-1:0]           dma_addr,
   output logic [DATA_W-1:0]           dma_wdata,
   output logic [DATA_W/8-1:0]         dma_wstrb,
   input  logic                        dma_ready,
   output logic [N_REQ-1:0]            grant,
   output logic                        busy
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W  = burst_cnt_w(BURST_LEN);

   arb_state_e        state_q, state_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  win_idx_q, win_idx_d;

   logic [N_REQ-1:0]  arb_onehot_c;
   logic [PTR_W-1:0]  arb_idx_c;
   logic [ADDR_W-1:0] arb_addr_c;
   logic              last_beat_c;

   rr_arbiter_comb #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req          (req_valid),
      .ptr          (ptr_q),
      .win_onehot_c (arb_onehot_c),
      .win_idx_c    (arb_idx_c)
   );

   assign arb_addr_c  = ADDR_W'(req_addr >> (32'(arb_idx_c) * ADDR_W));
   assign last_beat_c = dma_ready && (cnt_q == CNT_W'(BURST_LEN - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         grant_q   <= '0;
         busy_q    <= 1'b0;
         addr_q    <= '0;
         cnt_q     <= '0;
         ptr_q     <= '0;
         win_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         win_idx_q <= win_idx_d;
      end
   end

   // Grant is taken only from IDLE, so a burst always ends with one idle cycle.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      busy_d    = busy_q;
      addr_d    = addr_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      win_idx_d = win_idx_q;
      case (state_q)
         ARB_IDLE: begin
            if (|req_valid) begin
               state_d   = ARB_BURST;
               grant_d   = arb_onehot_c;
               busy_d    = 1'b1;
               addr_d    = arb_addr_c;
               cnt_d     = '0;
               win_idx_d = arb_idx_c;
            end
         end
         ARB_BURST: begin
            if (last_beat_c) begin
               state_d = ARB_IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
               cnt_d   = '0;
`ifdef AXI_DMA_W_ARB_PRIO_EN
               ptr_d   = '0;
`else
               ptr_d   = (win_idx_q == PTR_W'(N_REQ - 1)) ? '0 : win_idx_q + PTR_W'(1);
`endif
            end else if (dma_ready) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   // grant_q is zero in IDLE, which also masks dma_ready there.
   assign req_ready = grant_q & {N_REQ{dma_ready}};
   assign dma_valid = |(req_valid & grant_q);
   assign dma_addr  = addr_q;
   assign dma_wdata = DATA_W'(req_wdata >> (32'(win_idx_q) * DATA_W));
   assign dma_wstrb = STRB_W'(req_wstrb >> (32'(win_idx_q) * STRB_W));
   assign grant     = grant_q;
   assign busy      = busy_q;

endmodule

// File: doc/axi_dma_w_arb.md
Name: axi_dma_w_arb

Overview:
- Burst-granular arbiter that shares one AXI write-DMA engine among N_REQ requesters, e.g. CNN layer output writers and the debug dump path.
- Each requester presents a burst base address plus a data/strobe stream on a valid/ready databus.
- The arbiter grants one requester for exactly BURST_LEN accepted beats, then re-arbitrates.
- It sits between the layer write units and the write-DMA engine's databus port.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- ADDR_W, 30, DDR byte address width.
- DATA_W, 256, data beat width; strobe width is DATA_W/8.
- BURST_LEN, 16, beats per burst; must match the engine's fixed burst length.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  N_REQ  per-requester burst request / beat valid.
- req_addr  in  N_REQ*ADDR_W  per-requester burst base address, flattened; slot i = bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  per-requester beat data, flattened.
- req_wstrb  in  N_REQ*DATA_W/8  per-requester beat strobes, flattened.
- req_ready  out  N_REQ  per-requester beat-accepted pulse.
- dma_valid  out  1  request to the engine.
- dma_addr  out  ADDR_W  burst base address to the engine.
- dma_wdata  out  DATA_W  beat data to the engine.
- dma_wstrb  out  DATA_W/8  beat strobes to the engine.
- dma_ready  in  1  engine beat-accepted pulse; one pulse per beat.
- grant  out  N_REQ  one-hot owner of the current burst; zero when idle.
- busy  out  1  high while a burst is owned.

Behaviour:
- Reset values:
  - state IDLE, grant 0, busy 0, dma_valid 0, dma_addr 0.
  - Beat counter 0; round-robin pointer 0.
  - req_ready 0.
- IDLE:
  - If any req_valid is high, select a winner round-robin, starting the search at pointer.
  - On the next clk edge: register grant as one-hot of the winner, latch dma_addr from req_addr[winner], set busy, go to BURST.
  - Grant latency: 1 cycle from req_valid to grant/dma_valid.
- BURST:
  - dma_valid = req_valid[winner].
  - dma_wdata / dma_wstrb are combinationally muxed from the winner's slot.
  - dma_addr holds the latched value for the whole burst; requester address changes are ignored.
  - req_ready[i] = dma_ready & grant[i]; non-winners always see 0.
  - Beat counter increments on every dma_ready.
  - Beats are counted regardless of dma_valid: a granted requester must present valid data on every beat.
- End of burst: dma_ready with counter == BURST_LEN-1 is the last beat. On the following edge:
  - counter returns to 0; grant and busy clear; dma_valid drops.
  - pointer = (winner+1) mod N_REQ; state returns to IDLE.
  - No back-to-back grant in the same cycle: there is at least one IDLE cycle between bursts. This is hidden by the engine's write-response phase.
- Grant is never preempted mid-burst.
- A requester deasserting req_valid mid-burst keeps its grant; dma_valid follows it low.
- dma_ready in IDLE is ignored: no req_ready and no count.
- Simultaneous requests: round-robin order from pointer; a sole requester is granted repeatedly.
- Reset mid-burst: all state clears immediately. The engine shares rst, so no partial-burst recovery is required.
- Counter width is clog2(BURST_LEN)+1 bits and never wraps past BURST_LEN-1.

Optional Feature:
- Macro: AXI_DMA_W_ARB_PRIO_EN.
- Defined: fixed priority; the lowest index wins and the pointer is unused (held at 0).
- Undefined: round-robin as above.
- Grant latency, burst locking and all other behaviour are identical in both modes.

Decomposition:
- Shared package / include: state encodings (ARB_IDLE=1'b0, ARB_BURST=1'b1), the default BURST_LEN constant, and the burst counter width function.
- One sub-module, rr_arbiter_comb: combinational N_REQ-input arbiter taking req vector and pointer, returning one-hot winner plus its index; the priority variant is selected inside it under the macro.
- Grant/counter registers and the muxes stay in the top module.

Test Plan:
1. Single burst: req_valid=2'b01, req_addr[0]=0x100.
   - grant=01 one cycle later; dma_addr=0x100.
   - 16 dma_ready pulses → 16 req_ready[0] pulses, then grant=00 and busy=0.
2. Round-robin: both requesters valid continuously.
   - Grants alternate 01,10,01,10 over 4 bursts, each exactly 16 beats, one IDLE cycle between bursts.
3. No preemption: requester 1 asserts at beat 5 of requester 0's burst.
   - Requester 0 completes all 16 beats; requester 1 is granted on the next burst.
   - req_ready[1] stays 0 throughout requester 0's burst.
4. Address stability: req_addr[0] changes 0x100→0x200 mid-burst.
   - dma_addr stays 0x100 until burst end.
5. Reset at beat 7: rst pulsed.
   - grant, busy, dma_valid, req_ready all 0 immediately.
   - The next request restarts at beat 0 with pointer 0.
6. With AXI_DMA_W_ARB_PRIO_EN: both requesters valid continuously.
   - grant=01 for every burst; requester 1 starves.
